// File: rtl/counter_sync_updown_mod_if.sv
// Control/status bundle for counter_sync_updown_mod.
// master drives the controls, slave is the counter itself.
interface counter_sync_updown_mod_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_flag;
    logic [WIDTH-1:0] out;
    logic             terminal;
    logic             wrapped;
    logic             overflow;

    modport master (
        output enable, up_down, load, load_value, clear_flag,
        input  out, terminal, wrapped, overflow
    );

    modport slave (
        input  enable, up_down, load, load_value, clear_flag,
        output out, terminal, wrapped, overflow
    );
endinterface

// File: rtl/counter_sync_updown_mod.sv
// Parametrised up/down counter: load with clamp, programmable top value,
// wrap or saturate at the boundaries, pulse and sticky boundary flags.
module counter_sync_updown_mod #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 15,
    parameter int          SATURATE  = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    counter_sync_updown_mod_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_sync_updown_mod: WIDTH must be 1..32");
    end

    if (MAX_VALUE < 1 ||
        64'(MAX_VALUE) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_sync_updown_mod: MAX_VALUE out of range");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] load_clamped;
    logic             at_bound;
    logic             step;
    logic             event_hit;
    logic             wrapped_q;
    logic             overflow_q;

    assign at_bound  = bus.up_down ? (cnt == MAXV) : (cnt == '0);
    assign step      = bus.enable & ~bus.load;
    assign event_hit = step & at_bound & ~reset;

    assign load_clamped =
        (bus.load_value > MAXV) ? MAXV : bus.load_value;

    always_comb begin
        cnt_nxt = cnt;
        unique case (1'b1)
            bus.load: begin
                cnt_nxt = load_clamped;
            end
            step & at_bound: begin
                if (SATURATE != 0)
                    cnt_nxt = cnt;
                else
                    cnt_nxt = bus.up_down ? '0 : MAXV;
            end
            step & ~at_bound & bus.up_down: begin
                cnt_nxt = cnt + WIDTH'(1);
            end
            step & ~at_bound & ~bus.up_down: begin
                cnt_nxt = cnt - WIDTH'(1);
            end
            default: begin
                cnt_nxt = cnt;
            end
        endcase
    end

    // set beats clear when both land on the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            wrapped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            wrapped_q  <= event_hit;
            overflow_q <= event_hit | (overflow_q & ~bus.clear_flag);
        end
    end

    assign bus.out      = cnt;
    assign bus.terminal = event_hit;
    assign bus.wrapped  = wrapped_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_counter_sync_updown_mod.sv
// Bench: three 4-bit counters (mod16 wrap, mod10 wrap, mod10 saturate)
// plus a two-stage cascade, checked by vectors and a reference model.
module tb_counter_sync_updown_mod;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rs;
        logic       en;
        logic       ud;
        logic       ld;
        logic       cf;
        logic [3:0] lv;
    } drv_t;

    drv_t       d [3];
    logic [3:0] o_out [3];
    logic       o_term [3];
    logic       o_wr [3];
    logic       o_ov [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        counter_sync_updown_mod_if #(.WIDTH(4)) bus ();
        assign bus.enable     = d[g].en;
        assign bus.up_down    = d[g].ud;
        assign bus.load       = d[g].ld;
        assign bus.load_value = d[g].lv;
        assign bus.clear_flag = d[g].cf;
        assign o_out[g]  = bus.out;
        assign o_term[g] = bus.terminal;
        assign o_wr[g]   = bus.wrapped;
        assign o_ov[g]   = bus.overflow;
        counter_sync_updown_mod #(
            .WIDTH(4),
            .MAX_VALUE((g == 0) ? 15 : 9),
            .SATURATE((g == 2) ? 1 : 0)
        ) u_dut (
            .clock(clock),
            .reset(d[g].rs),
            .bus(bus)
        );
    end

    // cascade: high stage steps on the low stage's terminal count
    logic c_rs;
    logic c_en;
    counter_sync_updown_mod_if #(.WIDTH(4)) bl ();
    counter_sync_updown_mod_if #(.WIDTH(4)) bh ();
    assign bl.enable     = c_en;
    assign bl.up_down    = 1'b1;
    assign bl.load       = 1'b0;
    assign bl.load_value = 4'd0;
    assign bl.clear_flag = 1'b0;
    assign bh.enable     = bl.terminal;
    assign bh.up_down    = 1'b1;
    assign bh.load       = 1'b0;
    assign bh.load_value = 4'd0;
    assign bh.clear_flag = 1'b0;

    counter_sync_updown_mod #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(0))
        u_lo (.clock(clock), .reset(c_rs), .bus(bl));
    counter_sync_updown_mod #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(0))
        u_hi (.clock(clock), .reset(c_rs), .bus(bh));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // reference model: plain modular / clamped arithmetic per config
    int m_out [3];
    int m_wr  [3];
    int m_ov  [3];

    function automatic int max_of(input int i);
        return (i == 0) ? 15 : 9;
    endfunction

    function automatic int exp_term(input int i);
        int at;
        at = d[i].ud ? int'(m_out[i] == max_of(i)) : int'(m_out[i] == 0);
        return (d[i].en && !d[i].ld && !d[i].rs && at != 0) ? 1 : 0;
    endfunction

    task automatic model_edge(input int i);
        int mx;
        int ev;
        mx = max_of(i);
        if (d[i].rs) begin
            m_out[i] = 0;
            m_wr[i]  = 0;
            m_ov[i]  = 0;
        end else if (d[i].ld) begin
            m_out[i] = (int'(d[i].lv) > mx) ? mx : int'(d[i].lv);
            m_wr[i]  = 0;
            m_ov[i]  = (m_ov[i] != 0 && !d[i].cf) ? 1 : 0;
        end else if (d[i].en) begin
            ev = exp_term(i);
            if (i == 2) begin
                if (d[i].ud) m_out[i] = (m_out[i] + 1 > mx) ? mx : m_out[i] + 1;
                else         m_out[i] = (m_out[i] == 0) ? 0 : m_out[i] - 1;
            end else begin
                if (d[i].ud) m_out[i] = (m_out[i] + 1) % (mx + 1);
                else         m_out[i] = (m_out[i] + mx) % (mx + 1);
            end
            m_wr[i] = ev;
            m_ov[i] = (ev != 0 || (m_ov[i] != 0 && !d[i].cf)) ? 1 : 0;
        end else begin
            m_wr[i] = 0;
            m_ov[i] = (m_ov[i] != 0 && !d[i].cf) ? 1 : 0;
        end
    endtask

    typedef struct {
        int rs, en, ud, ld, cf, lv;
        int out, term, wr, ov;
    } vec_t;

    vec_t tbl [22];

    function automatic drv_t to_drv(input vec_t v);
        drv_t r;
        r.rs = v.rs[0];
        r.en = v.en[0];
        r.ud = v.ud[0];
        r.ld = v.ld[0];
        r.cf = v.cf[0];
        r.lv = v.lv[3:0];
        return r;
    endfunction

    initial begin
        drv_t r;
        drv_t idle;
        int   cur;
        int   sat_out [4];
        int   sat_wr  [4];
        int   sat_tm  [4];

        idle = '0;
        for (int i = 0; i < 3; i++) d[i] = idle;
        c_rs = 1'b1;
        c_en = 1'b0;

        // randomized run on all three configs against the model
        for (int n = 0; n < 400; n++) begin
            r.rs = (n == 0) || ($urandom_range(0, 39) == 0);
            r.en = ($urandom_range(0, 3) != 0);
            r.ud = $urandom_range(0, 1) != 0;
            r.ld = ($urandom_range(0, 7) == 0);
            r.cf = ($urandom_range(0, 7) == 0);
            r.lv = 4'($urandom_range(0, 15));
            for (int i = 0; i < 3; i++) d[i] = r;
            #1;
            for (int i = 0; i < 3; i++)
                if (n > 0) chk("rnd_term", o_term[i], exp_term(i));
            for (int i = 0; i < 3; i++) model_edge(i);
            tick();
            for (int i = 0; i < 3; i++) begin
                chk("rnd_out", o_out[i], m_out[i]);
                chk("rnd_wrapped", o_wr[i], m_wr[i]);
                chk("rnd_overflow", o_ov[i], m_ov[i]);
            end
        end
        for (int i = 0; i < 3; i++) d[i] = idle;

        // vectors on the mod-10 wrap instance
        //          rs en ud ld cf lv  out tm wr ov
        tbl[0]  = '{1, 1, 1, 1, 0, 5,  0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 14, 9, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 2,  2, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 0,  9, 1, 1, 1};
        tbl[6]  = '{0, 1, 0, 0, 0, 0,  8, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,  8, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 1, 0,  8, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 9,  9, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 0, 0,  0, 1, 1, 1};
        tbl[11] = '{0, 1, 1, 1, 0, 3,  3, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 1, 0, 9,  9, 0, 0, 1};
        tbl[13] = '{0, 1, 1, 0, 1, 0,  0, 1, 1, 1};
        tbl[14] = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 0, 0, 0,  9, 1, 1, 1};
        tbl[16] = '{0, 0, 0, 1, 0, 7,  7, 0, 0, 1};
        tbl[17] = '{1, 1, 1, 1, 0, 4,  0, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 0};
        tbl[19] = '{0, 1, 0, 0, 0, 0,  9, 1, 1, 1};
        tbl[20] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 1};
        tbl[21] = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0};
        for (int k = 0; k < 22; k++) begin
            d[1] = to_drv(tbl[k]);
            #1;
            chk("vec_term", o_term[1], tbl[k].term);
            tick();
            chk("vec_out", o_out[1], tbl[k].out);
            chk("vec_wrapped", o_wr[1], tbl[k].wr);
            chk("vec_overflow", o_ov[1], tbl[k].ov);
        end
        d[1] = idle;

        // mod-16 wrap: 17 up steps from reset
        d[0] = idle;
        d[0].rs = 1'b1;
        tick();
        chk("rst_out", o_out[0], 0);
        chk("rst_wrapped", o_wr[0], 0);
        chk("rst_overflow", o_ov[0], 0);
        d[0] = idle;
        d[0].en = 1'b1;
        d[0].ud = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cur = (k - 1) % 16;
            #1;
            chk("up_term", o_term[0], (cur == 15) ? 1 : 0);
            tick();
            chk("up_out", o_out[0], k % 16);
            chk("up_wrapped", o_wr[0], (k == 16) ? 1 : 0);
            chk("up_overflow", o_ov[0], (k >= 16) ? 1 : 0);
        end
        d[0] = idle;

        // saturate: load 8, up x3 (8->9, hold, hold), then down once
        sat_out = '{9, 9, 9, 8};
        sat_wr  = '{0, 1, 1, 0};
        sat_tm  = '{0, 1, 1, 0};
        d[2] = idle;
        d[2].rs = 1'b1;
        tick();
        d[2] = idle;
        d[2].ld = 1'b1;
        d[2].lv = 4'd8;
        tick();
        chk("sat_load", o_out[2], 8);
        for (int k = 0; k < 4; k++) begin
            d[2] = idle;
            d[2].en = 1'b1;
            d[2].ud = (k < 3);
            #1;
            chk("sat_term", o_term[2], sat_tm[k]);
            tick();
            chk("sat_out", o_out[2], sat_out[k]);
            chk("sat_wrapped", o_wr[2], sat_wr[k]);
        end
        chk("sat_overflow", o_ov[2], 1);
        d[2] = idle;

        // cascade: 8-bit count 0..255 then back to 0
        c_rs = 1'b1;
        c_en = 1'b0;
        tick();
        chk("casc_rst", {bh.out, bl.out}, 0);
        c_rs = 1'b0;
        c_en = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            tick();
            chk("casc_out", {bh.out, bl.out}, k % 256);
        end
        c_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
